uart_tx_fifo_feeder: RTL and testbench

Byte-buffering front end for the UART transmitter. Accepts bytes from the system side into a synchronous FIFO and dispenses them one at a time to the transmitter through its data/request/busy/done handshake. The next byte is issued only after the previous frame reports done. Sits directly upstream of the UART transmitter, for example in the loopback path after the receiver.

---
 rtl/uart_tx_fifo_feeder.sv | 145 ++++++++++++++
 tb/tb_uart_tx_fifo_feeder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO in front of the UART transmitter: buffers system-side pushes and
// issues one byte per frame through the data/request/busy/done handshake.
module uart_tx_fifo_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_req,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic                  feeder_idle
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_C    = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO_C = {(ADDR_WIDTH + 1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE_C  = (ADDR_WIDTH + 1)'(1'b1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO_C = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C  = ADDR_WIDTH'(1'b1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO_C = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  overflow_r;
    logic [DATA_WIDTH-1:0] tx_data_r;
    logic                  tx_req_r;
    logic                  idle_r;
    state_t                state_r;
    state_t                state_next_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ADDR_WIDTH:0]   count_next_s;

    // Push/pop qualification; a byte is issued only from IDLE to an idle transmitter.
    always_comb begin
        push_s = wr_en & ~full_r;
        pop_s  = (state_r == ST_IDLE) && (count_r != CNT_ZERO_C) && !tx_busy;
    end

    // Occupancy after this edge.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE_C;
            2'b01:   count_next_s = count_r - CNT_ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // Handshake FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_next_s = ST_WAIT_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next_s = ST_WAIT_DONE;
                end else begin
                    state_next_s = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care after reset since pointers restart.
    always_ff @(posedge sysclk) begin
        if (push_s && !rst) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, flags, FSM state and all registered outputs.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            wr_ptr_r   <= PTR_ZERO_C;
            rd_ptr_r   <= PTR_ZERO_C;
            count_r    <= CNT_ZERO_C;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
            tx_data_r  <= DATA_ZERO_C;
            tx_req_r   <= 1'b0;
            idle_r     <= 1'b1;
            state_r    <= ST_IDLE;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + PTR_ONE_C;
                tx_data_r <= mem_r[rd_ptr_r];
            end
            if (wr_en && full_r) begin
                overflow_r <= 1'b1;
            end
            count_r  <= count_next_s;
            full_r   <= (count_next_s == DEPTH_C);
            empty_r  <= (count_next_s == CNT_ZERO_C);
            tx_req_r <= pop_s;
            idle_r   <= (state_next_s == ST_IDLE) && (count_next_s == CNT_ZERO_C);
            state_r  <= state_next_s;
        end
    end

    assign fifo_full   = full_r;
    assign fifo_empty  = empty_r;
    assign fifo_count  = count_r;
    assign overflow    = overflow_r;
    assign tx_data     = tx_data_r;
    assign tx_data_req = tx_req_r;
    assign feeder_idle = idle_r;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Bench for uart_tx_fifo_feeder: a 1-clock-per-bit transmitter model feeds a
// received-frame queue that is compared against the bytes pushed.
module tb_uart_tx_fifo_feeder;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] fifo_count;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_data_req;
    logic       tx_busy;
    logic       tx_done;
    logic       feeder_idle;

    logic       force_busy = 1'b0;
    logic       mdl_active = 1'b0;
    logic       mdl_done = 1'b0;
    logic [9:0] mdl_frame = 10'h3FF;
    logic [9:0] rx_bits = 10'h000;
    logic [3:0] bit_idx = 4'd0;
    int         req_cnt = 0;
    int         proto_err = 0;

    logic [7:0] exp_q[$];
    logic [9:0] rx_q[$];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    uart_tx_fifo_feeder #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .ADDR_WIDTH(4)) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .tx_data     (tx_data),
        .tx_data_req (tx_data_req),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .feeder_idle (feeder_idle)
    );

    always #5 sysclk = ~sysclk;

    assign tx_busy = mdl_active | force_busy;
    assign tx_done = mdl_done;

    // Transmitter model: serialises start, 8 data bits LSB first, stop.
    always @(posedge sysclk) begin
        if (mdl_active) begin
            if (tx_data_req) proto_err <= proto_err + 1;
            rx_bits   <= {mdl_frame[0], rx_bits[9:1]};
            mdl_frame <= {1'b1, mdl_frame[9:1]};
            if (bit_idx == 4'd9) begin
                mdl_active <= 1'b0;
                mdl_done   <= 1'b1;
                rx_q.push_back({mdl_frame[0], rx_bits[9:1]});
            end else begin
                bit_idx  <= bit_idx + 4'd1;
                mdl_done <= 1'b0;
            end
        end else begin
            mdl_done <= 1'b0;
            if (tx_data_req) begin
                if (force_busy) proto_err <= proto_err + 1;
                mdl_active <= 1'b1;
                mdl_frame  <= {1'b1, tx_data, 1'b0};
                bit_idx    <= 4'd0;
                req_cnt    <= req_cnt + 1;
            end
        end
    end

    task automatic apply_reset();
        @(negedge sysclk);
        rst = 1'b1;
        wr_en = 1'b0;
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
    endtask

    task automatic push_seq(input logic [7:0] first, input int n, input int n_exp);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            wr_data = first + 8'(i);
            if (i < n_exp) exp_q.push_back(first + 8'(i));
            @(negedge sysclk);
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        logic [9:0] got;
        logic [7:0] want;
        @(negedge sysclk);
        while (!(feeder_idle && !mdl_active && !mdl_done) && cyc < 3000) begin
            @(negedge sysclk);
            cyc++;
        end
        total_cnt++;
        if (cyc >= 3000) $display("FAIL %s_timeout: drain did not finish, %0d frames received", name, rx_q.size());
        else pass_cnt++;
        total_cnt++;
        if (rx_q.size() !== exp_q.size())
            $display("FAIL %s_frames: got %0d frames, expected %0d", name, rx_q.size(), exp_q.size());
        else pass_cnt++;
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            got = rx_q.pop_front();
            want = exp_q.pop_front();
            total_cnt++;
            if (got !== {1'b1, want, 1'b0})
                $display("FAIL %s_frame: got %b, expected %b", name, got, {1'b1, want, 1'b0});
            else pass_cnt++;
        end
        total_cnt++;
        if (proto_err !== 0) $display("FAIL %s_handshake: protocol errors %0d, expected 0", name, proto_err);
        else pass_cnt++;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        total_cnt++;
        if ({fifo_empty, fifo_full, fifo_count, overflow, tx_data_req, feeder_idle} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_flags: empty=%b full=%b count=%0d ovf=%b req=%b idle=%b, expected 1 0 0 0 0 1",
                     fifo_empty, fifo_full, fifo_count, overflow, tx_data_req, feeder_idle);
        else pass_cnt++;
        total_cnt++;
        if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h, expected 00", tx_data);
        else pass_cnt++;
    endtask

    task automatic test_single();
        wr_en = 1'b1;
        wr_data = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge sysclk);
        wr_en = 1'b0;
        total_cnt++;
        if (tx_data_req !== 1'b0 || fifo_count !== 5'd1)
            $display("FAIL single_stored: req=%b count=%0d, expected 0 1", tx_data_req, fifo_count);
        else pass_cnt++;
        @(negedge sysclk);
        total_cnt++;
        if (tx_data_req !== 1'b1 || tx_data !== 8'hA5 || fifo_empty !== 1'b1)
            $display("FAIL single_issue: req=%b data=%h empty=%b, expected 1 a5 1", tx_data_req, tx_data, fifo_empty);
        else pass_cnt++;
        @(negedge sysclk);
        total_cnt++;
        if (tx_data_req !== 1'b0) $display("FAIL single_pulse: req=%b, expected 0", tx_data_req);
        else pass_cnt++;
        wait_drain("single");
    endtask

    task automatic test_back_to_back();
        logic [4:0] want_cnt [3] = '{5'd1, 5'd1, 5'd2};
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h01 + 8'(i);
            exp_q.push_back(8'h01 + 8'(i));
            @(negedge sysclk);
            total_cnt++;
            if (fifo_count !== want_cnt[i])
                $display("FAIL b2b_count%0d: got %0d, expected %0d", i, fifo_count, want_cnt[i]);
            else pass_cnt++;
        end
        wr_en = 1'b0;
        wait_drain("b2b");
    endtask

    task automatic test_overflow();
        force_busy = 1'b1;
        push_seq(8'h10, 17, 16);
        total_cnt++;
        if ({fifo_full, overflow, fifo_count, fifo_empty} !== {1'b1, 1'b1, 5'd16, 1'b0})
            $display("FAIL ovf_flags: full=%b ovf=%b count=%0d empty=%b, expected 1 1 16 0",
                     fifo_full, overflow, fifo_count, fifo_empty);
        else pass_cnt++;
        force_busy = 1'b0;
        wait_drain("ovf");
        apply_reset();
    endtask

    task automatic test_wrap();
        int cyc = 0;
        int max_cnt = 0;
        force_busy = 1'b1;
        push_seq(8'h40, 16, 16);
        force_busy = 1'b0;
        while (rx_q.size() < 10 && cyc < 2000) begin
            @(negedge sysclk);
            cyc++;
        end
        total_cnt++;
        if (cyc >= 2000) $display("FAIL wrap_first10: got %0d frames, expected 10", rx_q.size());
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h80 + 8'(i);
            exp_q.push_back(8'h80 + 8'(i));
            @(negedge sysclk);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
        wr_en = 1'b0;
        total_cnt++;
        if (max_cnt > 16) $display("FAIL wrap_max_count: got %0d, expected <= 16", max_cnt);
        else pass_cnt++;
        wait_drain("wrap");
        total_cnt++;
        if (overflow !== 1'b0) $display("FAIL wrap_overflow: got %b, expected 0", overflow);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        int req_snap;
        push_seq(8'hC0, 6, 6);
        while (!(mdl_active && fifo_count == 5'd5) && cyc < 200) begin
            @(negedge sysclk);
            cyc++;
        end
        repeat (2) @(negedge sysclk);
        total_cnt++;
        if (cyc >= 200 || !mdl_active) $display("FAIL rstmid_setup: active=%b count=%0d, expected 1 5", mdl_active, fifo_count);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
        total_cnt++;
        if ({fifo_count, fifo_empty, tx_data_req, feeder_idle} !== {5'd0, 1'b1, 1'b0, 1'b1})
            $display("FAIL rstmid_flags: count=%0d empty=%b req=%b idle=%b, expected 0 1 0 1",
                     fifo_count, fifo_empty, tx_data_req, feeder_idle);
        else pass_cnt++;
        req_snap = req_cnt;
        repeat (40) @(negedge sysclk);
        total_cnt++;
        if (req_cnt !== req_snap) $display("FAIL rstmid_no_req: got %0d requests, expected %0d", req_cnt, req_snap);
        else pass_cnt++;
        rx_q.delete();
        exp_q.delete();
        push_seq(8'h5A, 1, 1);
        wait_drain("rstmid");
    endtask

    task automatic test_full_pop();
        force_busy = 1'b1;
        push_seq(8'h20, 16, 16);
        force_busy = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'hEE;
        @(negedge sysclk);
        wr_en = 1'b0;
        total_cnt++;
        if ({fifo_count, overflow, fifo_full, tx_data_req} !== {5'd15, 1'b1, 1'b0, 1'b1})
            $display("FAIL fullpop_flags: count=%0d ovf=%b full=%b req=%b, expected 15 1 0 1",
                     fifo_count, overflow, fifo_full, tx_data_req);
        else pass_cnt++;
        total_cnt++;
        if (tx_data !== 8'h20) $display("FAIL fullpop_data: got %h, expected 20", tx_data);
        else pass_cnt++;
        wait_drain("fullpop");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_reset_mid();
        test_full_pop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
